addsub_selftest: RTL and testbench

Synthesizable built-in self-test controller for the 4-bit add/subtract unit (`fourbit_addsub`). On a start pulse it drives every combination of `a`, `b` and `sub` (512 vectors) into the unit and captures `s`/`cout` after a settle interval. It compares each result against an internal golden model and reports a pass/fail verdict, the error count and the first failing vector. It sits beside the adder on the lab board, so the checking a simulation bench does by eye runs in hardware.

---
 rtl/addsub_selftest.sv | 133 +++++++++++++
 tb/tb_addsub_selftest.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_selftest.sv
// addsub_selftest -- built-in self-test controller for the 4-bit add/subtract
// unit (fourbit_addsub). A start pulse sweeps all 512 {sub,a,b} vectors
// through the unit. Each vector is held for SETTLE_CYCLES cycles. The result
// is then sampled and compared against a 5-bit golden model. The controller
// reports a pass/fail verdict, the mismatch count and the first failing vector.
//
// Parameters
//   SETTLE_CYCLES  cycles a vector is held before sampling (1..15)
//   STOP_ON_FAIL   1 = end the sweep at the first mismatch, 0 = full sweep
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          one-cycle sweep request, honoured only in IDLE or DONE
//   a_o, b_o, sub_o  vector driven to the adder (straight from idx)
//   s_i, cout_i    adder result
//   busy           sweep in progress (SETTLE or CHECK)
//   done           sweep finished, held until next start or reset
//   pass           done with zero mismatches
//   err_count      number of mismatching vectors (0..512)
//   first_fail     index of first mismatching vector, 0 if none
module addsub_selftest #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter bit          STOP_ON_FAIL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] a_o,
   output logic [3:0] b_o,
   output logic       sub_o,
   input  logic [3:0] s_i,
   input  logic       cout_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [9:0] err_count,
   output logic [8:0] first_fail
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Settle counter runs 0 .. SETTLE_CYCLES-1 inside SETTLE.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state, state_nx;
   logic [8:0] idx, idx_nx;
   logic [3:0] cnt, cnt_nx;
   logic [9:0] err_nx;
   logic [8:0] first_fail_nx;
   logic [4:0] golden;
   logic       mismatch;

   // Vector index drives the adder directly.
   assign sub_o = idx[8];
   assign a_o   = idx[7:4];
   assign b_o   = idx[3:0];

   // Subtraction as a + ~b + 1; bit 4 is carry-out (1 = no borrow when subtracting).
   always_comb begin
      golden   = {1'b0, a_o} + {1'b0, (sub_o ? ~b_o : b_o)} + {4'b0000, sub_o};
      mismatch = ({cout_i, s_i} != golden);
   end

   always_comb begin
      state_nx      = state;
      idx_nx        = idx;
      cnt_nx        = cnt;
      err_nx        = err_count;
      first_fail_nx = first_fail;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               idx_nx        = '0;
               cnt_nx        = '0;
               err_nx        = '0;
               first_fail_nx = '0;
               state_nx      = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               state_nx = CHECK;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         CHECK: begin
            if (mismatch) begin
               err_nx = err_count + 10'd1;
               if (err_count == '0) begin
                  first_fail_nx = idx;
               end
            end
            // idx is left untouched on exit so the last/failing vector stays driven.
            if ((idx == '1) || (mismatch && STOP_ON_FAIL)) begin
               state_nx = DONE;
            end else begin
               idx_nx   = idx + 9'd1;
               cnt_nx   = '0;
               state_nx = SETTLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         err_count  <= '0;
         first_fail <= '0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         err_count  <= err_nx;
         first_fail <= first_fail_nx;
      end
   end

   always_comb begin
      busy = (state == SETTLE) || (state == CHECK);
      done = (state == DONE);
      pass = done && (err_count == '0);
   end

endmodule

// File: tb/tb_addsub_selftest.sv
// Bench for addsub_selftest. Three instances share clock and reset:
//   dut0  default parameters, adder model correct or with s[0] stuck at 0
//   dut1  STOP_ON_FAIL=1, adder model with cout inverted in subtract mode
//   dut2  SETTLE_CYCLES=1, adder model whose output lags by 1 or 2 cycles
module tb_addsub_selftest;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic [3:0] a0, b0, s0, a1, b1, s1, a2, b2, s2;
   logic       sub0, sub1, sub2, cout0, cout1, cout2;
   logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
   logic [9:0] err0, err1, err2;
   logic [8:0] ff0, ff1, ff2;
   logic [8:0] stage1, stage2;
   int         mode0 = 0;
   int         lag_sel = 1;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   // Reference adder: plain integer add/subtract, vector packed as {sub,a,b}.
   function automatic logic [4:0] gold(input logic [8:0] v);
      int a, b;
      logic [4:0] r;
      a = int'(v[7:4]);
      b = int'(v[3:0]);
      if (v[8]) r = {(a >= b), 4'(a - b)};
      else      r = 5'(a + b);
      return r;
   endfunction

   always_comb begin
      {cout0, s0} = gold({sub0, a0, b0});
      if (mode0 == 1) s0[0] = 1'b0;
   end

   always_comb begin
      {cout1, s1} = gold({sub1, a1, b1});
      if (sub1) cout1 = ~cout1;
   end

   always @(posedge clk) begin
      stage1 <= {sub2, a2, b2};
      stage2 <= stage1;
   end

   always_comb {cout2, s2} = gold((lag_sel == 1) ? stage1 : stage2);

   addsub_selftest dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .a_o(a0), .b_o(b0), .sub_o(sub0), .s_i(s0), .cout_i(cout0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
   );

   addsub_selftest #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .a_o(a1), .b_o(b1), .sub_o(sub1), .s_i(s1), .cout_i(cout1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
   );

   addsub_selftest #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .a_o(a2), .b_o(b2), .sub_o(sub2), .s_i(s2), .cout_i(cout2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail(ff2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({busy0, done0, pass0} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {busy0, done0, pass0});
      end
      checks++;
      if ({sub0, a0, b0} !== 9'd0) begin
         errors++;
         $display("FAIL reset_vector: got %0d expected 0", {sub0, a0, b0});
      end
      checks++;
      if ({err0, ff0} !== 19'd0) begin
         errors++;
         $display("FAIL reset_counts: got err=%0d first=%0d expected 0/0", err0, ff0);
      end
      rst_n = 1'b1;
      repeat (2) tick();
      checks++;
      if ({busy0, done0, busy1, done1, busy2, done2} !== 6'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got %b expected 000000",
                  {busy0, done0, busy1, done1, busy2, done2});
      end
   endtask

   task automatic test_default_sweep();
      int vec[4] = '{50, 226, 453, 309};
      logic [4:0] res[4] = '{5'b00101, 5'b10000, 5'b10111, 5'b01110};
      mode0 = 0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      checks++;
      if ({busy0, done0, sub0, a0, b0} !== 11'b10_000000000) begin
         errors++;
         $display("FAIL start_latency: got busy=%b done=%b vec=%0d expected 1/0/0",
                  busy0, done0, {sub0, a0, b0});
      end
      for (int c = 1; c <= 1536; c++) begin
         tick();
         for (int j = 0; j < 4; j++) begin
            if (c == 3 * vec[j]) begin
               checks++;
               if ({sub0, a0, b0} !== 9'(vec[j])) begin
                  errors++;
                  $display("FAIL vector_drive_%0d: got %0d expected %0d", j, {sub0, a0, b0}, vec[j]);
               end
               checks++;
               if ({cout0, s0} !== res[j]) begin
                  errors++;
                  $display("FAIL adder_result_%0d: got %b expected %b", j, {cout0, s0}, res[j]);
               end
            end
         end
         if (c == 1535) begin
            checks++;
            if ({busy0, done0} !== 2'b10) begin
               errors++;
               $display("FAIL sweep_not_early: got busy/done=%b expected 10", {busy0, done0});
            end
         end
      end
      checks++;
      if ({busy0, done0, pass0} !== 3'b011) begin
         errors++;
         $display("FAIL sweep_done: got busy/done/pass=%b expected 011", {busy0, done0, pass0});
      end
      checks++;
      if ({err0, ff0} !== 19'd0) begin
         errors++;
         $display("FAIL sweep_counts: got err=%0d first=%0d expected 0/0", err0, ff0);
      end
      checks++;
      if ({sub0, a0, b0} !== 9'd511) begin
         errors++;
         $display("FAIL sweep_idx_held: got %0d expected 511", {sub0, a0, b0});
      end
   endtask

   task automatic test_stuck_s0();
      mode0 = 1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 1536; c++) begin
         tick();
         if (c == 5) begin
            checks++;
            if (err0 !== 10'd0) begin
               errors++;
               $display("FAIL stuck_before_first: got err=%0d expected 0", err0);
            end
         end
         if (c == 6) begin
            checks++;
            if ({err0, ff0} !== {10'd1, 9'd1}) begin
               errors++;
               $display("FAIL stuck_first_update: got err=%0d first=%0d expected 1/1", err0, ff0);
            end
         end
      end
      checks++;
      if ({done0, pass0} !== 2'b10) begin
         errors++;
         $display("FAIL stuck_verdict: got done/pass=%b expected 10", {done0, pass0});
      end
      checks++;
      if ({err0, ff0} !== {10'd256, 9'd1}) begin
         errors++;
         $display("FAIL stuck_counts: got err=%0d first=%0d expected 256/1", err0, ff0);
      end
   endtask

   task automatic test_back_to_back();
      mode0 = 0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      checks++;
      if ({busy0, done0, err0, ff0} !== {2'b10, 19'd0}) begin
         errors++;
         $display("FAIL restart_clear: got busy=%b done=%b err=%0d first=%0d expected 1/0/0/0",
                  busy0, done0, err0, ff0);
      end
      for (int c = 1; c <= 1536; c++) begin
         tick();
         start0 = ((c == 99) || (c == 900) || (c == 1200)) ? 1'b1 : 1'b0;
         if (c == 1535) begin
            checks++;
            if ({busy0, done0} !== 2'b10) begin
               errors++;
               $display("FAIL ignore_start_timing: got busy/done=%b expected 10", {busy0, done0});
            end
         end
      end
      start0 = 1'b0;
      checks++;
      if ({done0, pass0, err0} !== {2'b11, 10'd0}) begin
         errors++;
         $display("FAIL restart_sweep: got done=%b pass=%b err=%0d expected 1/1/0", done0, pass0, err0);
      end
   endtask

   task automatic test_stop_on_fail();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int c = 1; c <= 771; c++) begin
         tick();
         if (c == 770) begin
            checks++;
            if ({busy1, done1} !== 2'b10) begin
               errors++;
               $display("FAIL stop_not_early: got busy/done=%b expected 10", {busy1, done1});
            end
         end
      end
      checks++;
      if ({busy1, done1, pass1} !== 3'b010) begin
         errors++;
         $display("FAIL stop_verdict: got busy/done/pass=%b expected 010", {busy1, done1, pass1});
      end
      checks++;
      if ({err1, ff1} !== {10'd1, 9'd256}) begin
         errors++;
         $display("FAIL stop_counts: got err=%0d first=%0d expected 1/256", err1, ff1);
      end
      repeat (10) tick();
      checks++;
      if ({done1, sub1, a1, b1} !== {1'b1, 9'd256}) begin
         errors++;
         $display("FAIL stop_vector_held: got done=%b vec=%0d expected 1/256", done1, {sub1, a1, b1});
      end
   endtask

   task automatic test_reset_mid_sweep();
      mode0 = 1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (700) tick();
      checks++;
      if (err0 === 10'd0) begin
         errors++;
         $display("FAIL midsweep_errors_present: got err=%0d expected nonzero", err0);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy0, done0, pass0, sub0, a0, b0} !== 12'd0) begin
         errors++;
         $display("FAIL async_reset_outputs: got busy=%b done=%b pass=%b vec=%0d expected all 0",
                  busy0, done0, pass0, {sub0, a0, b0});
      end
      checks++;
      if ({err0, ff0, done1, err1, ff1} !== 39'd0) begin
         errors++;
         $display("FAIL async_reset_counts: got err0=%0d ff0=%0d done1=%b err1=%0d ff1=%0d expected 0",
                  err0, ff0, done1, err1, ff1);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      mode0 = 0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (1536) tick();
      checks++;
      if ({done0, pass0, err0, ff0} !== {2'b11, 19'd0}) begin
         errors++;
         $display("FAIL post_reset_sweep: got done=%b pass=%b err=%0d first=%0d expected 1/1/0/0",
                  done0, pass0, err0, ff0);
      end
   endtask

   task automatic test_lag();
      int exp_err;
      lag_sel = 1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int c = 1; c <= 1024; c++) begin
         tick();
         if (c == 1023) begin
            checks++;
            if ({busy2, done2} !== 2'b10) begin
               errors++;
               $display("FAIL lag1_not_early: got busy/done=%b expected 10", {busy2, done2});
            end
         end
      end
      checks++;
      if ({busy2, done2, pass2, err2, ff2} !== {3'b011, 19'd0}) begin
         errors++;
         $display("FAIL lag1_verdict: got busy=%b done=%b pass=%b err=%0d first=%0d expected 0/1/1/0/0",
                  busy2, done2, pass2, err2, ff2);
      end
      // Two-cycle lag: each check sees the previous vector's result; vector 0
      // sees vector 511, which stays driven from the previous sweep.
      exp_err = 0;
      for (int k = 0; k < 512; k++) begin
         if (gold(9'(k)) != gold(9'((k + 511) % 512))) exp_err++;
      end
      lag_sel = 2;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (1024) tick();
      checks++;
      if ({done2, pass2} !== 2'b10) begin
         errors++;
         $display("FAIL lag2_verdict: got done/pass=%b expected 10", {done2, pass2});
      end
      checks++;
      if ({err2, ff2} !== {10'(exp_err), 9'd0}) begin
         errors++;
         $display("FAIL lag2_counts: got err=%0d first=%0d expected %0d/0", err2, ff2, exp_err);
      end
   endtask

   initial begin
      test_reset();
      test_default_sweep();
      test_stuck_s0();
      test_back_to_back();
      test_stop_on_fail();
      test_reset_mid_sweep();
      test_lag();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
